// File: rtl/imem_loader.sv
// Framed byte-stream boot loader: MAGIC, 16-bit length, payload, checksum.
// Payload bytes fill instruction memory from address 0; core is held until a good frame.
module imem_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter logic [7:0]  MAGIC  = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  typedef enum logic [2:0] {
    StIdle, StLenLo, StLenHi, StData, StCsum, StDone, StErr
  } state_e;

  // One past the highest address; a length equal to this fills memory exactly.
  localparam logic [16:0] Cap = 17'd1 << ADDR_W;

  state_e            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [16:0]       cnt_q, cnt_d, cnt_inc;
  logic [7:0]        sum_q, sum_d;
  logic              in_ready_q;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              load_done_q, load_done_d;
  logic              load_err_q, load_err_d;
  logic              accept;
  logic [16:0]       len_full;

  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_hold_d  = cpu_hold_q;
    load_done_d = load_done_q;
    load_err_d  = load_err_q;
    cnt_inc     = cnt_q + 17'd1;
    len_full    = {1'b0, in_data, len_q[7:0]};

    if (accept) begin
      unique case (state_q)
        StIdle, StDone, StErr: begin
          if (in_data == MAGIC) begin
            state_d     = StLenLo;
            load_done_d = 1'b0;
            load_err_d  = 1'b0;
            cpu_hold_d  = 1'b1;
            cnt_d       = '0;
            sum_d       = '0;
          end
        end
        StLenLo: begin
          len_d[7:0] = in_data;
          state_d    = StLenHi;
        end
        StLenHi: begin
          len_d[15:8] = in_data;
          // Oversize lengths are rejected here so addresses can never wrap.
          if (len_full > Cap) begin
            state_d    = StErr;
            load_err_d = 1'b1;
          end else if (len_full == 17'd0) begin
            state_d = StCsum;
          end else begin
            state_d = StData;
          end
        end
        StData: begin
          mem_we_d    = 1'b1;
          mem_addr_d  = cnt_q[ADDR_W-1:0];
          mem_wdata_d = in_data;
          sum_d       = sum_q + in_data;
          cnt_d       = cnt_inc;
          if (cnt_inc == {1'b0, len_q}) state_d = StCsum;
        end
        StCsum: begin
          if (in_data == sum_q) begin
            state_d     = StDone;
            load_done_d = 1'b1;
            cpu_hold_d  = 1'b0;
          end else begin
            state_d    = StErr;
            load_err_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      len_q       <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b1;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      in_ready_q  <= 1'b1;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad frames, size limits, gaps and mid-frame reset.
module tb_imem_loader;
  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          cpu_hold;
  logic          load_done;
  logic          load_err;

  int checks = 0;
  int passes = 0;
  logic [7:0] wq_a[$];
  logic [7:0] wq_d[$];
  logic [7:0] prog[8];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(AW), .MAGIC(8'hA5)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  // Record every write strobe once per cycle.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wq_a.push_back(mem_addr);
      wq_d.push_back(mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // A5 on the bus with in_valid low must never be taken as a magic byte.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'hA5;
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic prog_frame(input logic [7:0] cs);
    send(8'hA5); send(8'h08); send(8'h00);
    for (int i = 0; i < 8; i++) begin
      send(prog[i]);
      check("pay_we", {31'd0, mem_we}, 32'd1);
      check("pay_addr", {24'd0, mem_addr}, i);
      check("pay_data", {24'd0, mem_wdata}, {24'd0, prog[i]});
    end
    send(cs);
  endtask

  task automatic check_writes(input string tag, input int n);
    int bad;
    bad = 0;
    check({tag, "_nwr"}, wq_a.size(), n);
    for (int i = 0; i < wq_a.size(); i++)
      if (wq_a[i] !== 8'(i) || wq_d[i] !== prog[i % 8]) bad++;
    check({tag, "_wrbad"}, bad, 0);
  endtask

  initial begin
    int g;
    int bad;
    logic [7:0] pay4[4];
    prog = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    pay4 = '{8'h11, 8'h22, 8'h33, 8'h44};
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, in_ready}, 0);
    check("rst_we", {31'd0, mem_we}, 0);
    check("rst_addr", {24'd0, mem_addr}, 0);
    check("rst_wdata", {24'd0, mem_wdata}, 0);
    check("rst_hold", {31'd0, cpu_hold}, 1);
    check("rst_done", {31'd0, load_done}, 0);
    check("rst_err", {31'd0, load_err}, 0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    check("ready_up", {31'd0, in_ready}, 1);

    // Garbage before magic, then a good frame
    send(8'h00); send(8'hFF); send(8'h5A);
    check("garb_hold", {31'd0, cpu_hold}, 1);
    check("garb_done", {31'd0, load_done}, 0);
    check("garb_nwr", wq_a.size(), 0);
    prog_frame(8'hB6);
    check("good_done", {31'd0, load_done}, 1);
    check("good_hold", {31'd0, cpu_hold}, 0);
    check("good_err", {31'd0, load_err}, 0);
    check_writes("good", 8);

    // Bad checksum: writes still happen, core stays held
    wq_a.delete(); wq_d.delete();
    prog_frame(8'hB7);
    check("bad_err", {31'd0, load_err}, 1);
    check("bad_done", {31'd0, load_done}, 0);
    check("bad_hold", {31'd0, cpu_hold}, 1);
    check_writes("bad", 8);
    prog_frame(8'hB6);
    check("recov_done", {31'd0, load_done}, 1);
    check("recov_err", {31'd0, load_err}, 0);

    // Oversize length rejected right after the high length byte
    wq_a.delete(); wq_d.delete();
    send(8'hA5);
    check("magic_clr_done", {31'd0, load_done}, 0);
    check("magic_hold", {31'd0, cpu_hold}, 1);
    send(8'h01); send(8'h01);
    check("over_err", {31'd0, load_err}, 1);
    send(8'h13); send(8'h00);
    check("over_nwr", wq_a.size(), 0);
    check("over_err2", {31'd0, load_err}, 1);

    // Exactly full memory: 256 bytes of i, checksum 0x80
    send(8'hA5); send(8'h00); send(8'h01);
    check("full_err_clr", {31'd0, load_err}, 0);
    for (int i = 0; i < 256; i++) send(8'(i));
    check("full_notdone", {31'd0, load_done}, 0);
    send(8'h80);
    check("full_done", {31'd0, load_done}, 1);
    check("full_nwr", wq_a.size(), 256);
    bad = 0;
    for (int i = 0; i < wq_a.size(); i++)
      if (wq_a[i] !== 8'(i) || wq_d[i] !== 8'(i)) bad++;
    check("full_wrbad", bad, 0);

    // Gaps in in_valid during the payload
    wq_a.delete(); wq_d.delete();
    send(8'hA5); send(8'h04); send(8'h00);
    for (int i = 0; i < 4; i++) begin
      g = int'($urandom_range(0, 2));
      gap(g);
      if (g > 0) check("gap_we", {31'd0, mem_we}, 0);
      send(pay4[i]);
    end
    send(8'hAA);
    check("gap_done", {31'd0, load_done}, 1);
    check("gap_nwr", wq_a.size(), 4);
    bad = 0;
    for (int i = 0; i < wq_a.size(); i++)
      if (wq_a[i] !== 8'(i) || wq_d[i] !== pay4[i % 4]) bad++;
    check("gap_wrbad", bad, 0);

    // Reset after three payload bytes
    wq_a.delete(); wq_d.delete();
    send(8'hA5); send(8'h08); send(8'h00);
    send(prog[0]); send(prog[1]); send(prog[2]);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_ready", {31'd0, in_ready}, 0);
    check("mid_we", {31'd0, mem_we}, 0);
    check("mid_addr", {24'd0, mem_addr}, 0);
    check("mid_hold", {31'd0, cpu_hold}, 1);
    check("mid_done", {31'd0, load_done}, 0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    wq_a.delete(); wq_d.delete();
    prog_frame(8'hB6);
    check("mid_rec_done", {31'd0, load_done}, 1);
    check_writes("mid_rec", 8);

    // Zero-length frames
    wq_a.delete(); wq_d.delete();
    send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
    check("zero_done", {31'd0, load_done}, 1);
    check("zero_nwr", wq_a.size(), 0);
    send(8'hA5); send(8'h00); send(8'h00); send(8'h01);
    check("zero_bad_err", {31'd0, load_err}, 1);
    check("zero_bad_hold", {31'd0, cpu_hold}, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
